// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA ASIP MODEX sequencer.
package rsa_pkg;

  // Default datapath width of the ASIP.
  localparam int ARQ = 16;

  // Width of the serial multiplier's iteration counter.
  localparam int CNT_W = 5;

  // Sequencer states. The NEXT decision has no state of its own: it is
  // evaluated on the transition out of REDUCE, MUL and SQR.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MUL    = 3'd2,
    ST_SQR    = 3'd3,
    ST_DONE   = 3'd4
  } modex_state_t;

  // Which operand pair is routed into the shared modular multiplier.
  typedef enum logic [1:0] {
    OP_REDUCE = 2'd0,
    OP_MUL    = 2'd1,
    OP_SQR    = 2'd2
  } modmul_op_t;

endpackage

// File: rtl/modmul_serial.sv
// Interleaved shift-add modular multiplier: p = (a * b) mod m.
// One load cycle (go) followed by ARQ iterations over a, MSB first.
// valid is high during the last iteration cycle and p is that
// iteration's reduced sum, so the caller captures p on the same edge
// the multiplier finishes.
module modmul_serial #(
  parameter int ARQ = rsa_pkg::ARQ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [ARQ-1:0] a,
  input  logic [ARQ-1:0] b,
  input  logic [ARQ-1:0] m,
  output logic           valid,
  output logic [ARQ-1:0] p
);
  import rsa_pkg::*;

  logic [ARQ-1:0]   a_sh;
  logic [ARQ-1:0]   b_r;
  logic [ARQ-1:0]   m_r;
  logic [ARQ:0]     acc;
  logic [ARQ:0]     dbl;
  logic [ARQ:0]     dbl_red;
  logic [ARQ:0]     sum;
  logic [ARQ:0]     sum_red;
  logic [CNT_W-1:0] cnt;
  logic             running;

  // One iteration: double, reduce once, add b if the current a bit is set,
  // reduce once more. acc < m on entry keeps both sums below 2m.
  always_comb begin
    dbl     = acc << 1;
    dbl_red = (dbl >= {1'b0, m_r}) ? (dbl - {1'b0, m_r}) : dbl;
    sum     = dbl_red + (a_sh[ARQ-1] ? {1'b0, b_r} : {(ARQ+1){1'b0}});
    sum_red = (sum >= {1'b0, m_r}) ? (sum - {1'b0, m_r}) : sum;
  end

  assign valid = running && (cnt == CNT_W'(1));
  assign p     = sum_red[ARQ-1:0];

  // Operand load on go, then one iteration per cycle until the count runs out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh    <= '0;
      b_r     <= '0;
      m_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (go) begin
      a_sh    <= a;
      b_r     <= b;
      m_r     <= m;
      acc     <= '0;
      cnt     <= CNT_W'(ARQ);
      running <= 1'b1;
    end else if (running) begin
      a_sh <= a_sh << 1;
      acc  <= sum_red;
      cnt  <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/modex_controller.sv
// MODEX sequencer: result = base^exponent mod modulus by right-to-left
// square-and-multiply on one shared serial modular multiplier.
//
// Handshake: start is a request level sampled only while idle; it is
// accepted on the rising edge where state is IDLE and start is 1, and is
// ignored in every other state. done is a one-cycle pulse with result and
// err valid in that cycle; there is no back-pressure on the result.
// stall follows combinationally so the PC freezes in the issue cycle.
module modex_controller #(
  parameter int ARQ = rsa_pkg::ARQ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ARQ-1:0] base,
  input  logic [ARQ-1:0] exponent,
  input  logic [ARQ-1:0] modulus,
  output logic           stall,
  output logic           busy,
  output logic           done,
  output logic           wr_reg_en,
  output logic [ARQ-1:0] result,
  output logic           err,
  output logic [2:0]     debug_state
);
  import rsa_pkg::*;

  modex_state_t state;
  modex_state_t state_nxt;
  modmul_op_t   mm_op;

  logic [ARQ-1:0] base_r;
  logic [ARQ-1:0] mod_r;
  logic [ARQ-1:0] acc;
  logic [ARQ-1:0] b;
  logic [ARQ-1:0] e;
  logic [ARQ-1:0] result_r;
  logic           err_r;
  logic           launch;
  logic           launch_nxt;

  logic [ARQ-1:0] mm_a;
  logic [ARQ-1:0] mm_b;
  logic           mm_valid;
  logic [ARQ-1:0] mm_p;

  // The NEXT decision for a given remaining exponent.
  function automatic modex_state_t next_step(input logic [ARQ-1:0] ev);
    if (ev == '0)   return ST_DONE;
    else if (ev[0]) return ST_MUL;
    else            return ST_SQR;
  endfunction

  function automatic logic uses_modmul(input modex_state_t s);
    return (s == ST_REDUCE) || (s == ST_MUL) || (s == ST_SQR);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a multiplier state is left only when its product is ready.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (modulus == '0) ? ST_DONE : ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (mm_valid) state_nxt = next_step(e);
      end
      ST_MUL: begin
        if (mm_valid) state_nxt = (e[ARQ-1:1] == '0) ? ST_DONE : ST_SQR;
      end
      ST_SQR: begin
        if (mm_valid) state_nxt = next_step(e >> 1);
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A new multiplication starts whenever a multiplier state is entered or re-entered.
  always_comb begin
    launch_nxt = 1'b0;
    if (uses_modmul(state_nxt) && ((state_nxt != state) || mm_valid)) begin
      launch_nxt = 1'b1;
    end
  end

  // Operand muxes into the shared multiplier; a is the multiplier-bit path.
  always_comb begin
    mm_op = OP_REDUCE;
    mm_a  = base_r;
    mm_b  = {{(ARQ-1){1'b0}}, 1'b1};
    case (state)
      ST_MUL:  mm_op = OP_MUL;
      ST_SQR:  mm_op = OP_SQR;
      default: mm_op = OP_REDUCE;
    endcase
    case (mm_op)
      OP_MUL: begin
        mm_a = acc;
        mm_b = b;
      end
      OP_SQR: begin
        mm_a = b;
        mm_b = b;
      end
      default: begin
        mm_a = base_r;
        mm_b = {{(ARQ-1){1'b0}}, 1'b1};
      end
    endcase
  end

  // Operand capture, accumulator/base/exponent updates and result latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r   <= '0;
      mod_r    <= '0;
      acc      <= '0;
      b        <= '0;
      e        <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
      launch   <= 1'b0;
    end else begin
      launch <= launch_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_r <= base;
            mod_r  <= modulus;
            e      <= exponent;
            err_r  <= (modulus == '0);
            acc    <= (modulus > {{(ARQ-1){1'b0}}, 1'b1}) ? {{(ARQ-1){1'b0}}, 1'b1} : '0;
          end
        end
        ST_REDUCE: begin
          if (mm_valid) b <= mm_p;
        end
        ST_MUL: begin
          if (mm_valid) begin
            acc <= mm_p;
            if (e[ARQ-1:1] == '0) e <= e >> 1;
          end
        end
        ST_SQR: begin
          if (mm_valid) begin
            b <= mm_p;
            e <= e >> 1;
          end
        end
        ST_DONE: begin
          result_r <= acc;
        end
        default: begin
        end
      endcase
    end
  end

  modmul_serial #(.ARQ(ARQ)) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .go    (launch),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mod_r),
    .valid (mm_valid),
    .p     (mm_p)
  );

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign stall       = busy | (start & (state == ST_IDLE));
  assign err         = err_r;
  assign wr_reg_en   = done & ~err_r;
  assign result      = done ? acc : result_r;
  assign debug_state = state;

endmodule

// File: tb/tb_modex_controller.sv
// Self-checking bench for modex_controller: directed cases plus random
// operations against a plain-arithmetic modular exponentiation model.
module tb_modex_controller;
  localparam int ARQ     = 16;
  localparam int MAX_CYC = 700;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [ARQ-1:0] base = '0;
  logic [ARQ-1:0] exponent = '0;
  logic [ARQ-1:0] modulus = '0;
  logic           stall;
  logic           busy;
  logic           done;
  logic           wr_reg_en;
  logic [ARQ-1:0] result;
  logic           err;
  logic [2:0]     debug_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ARQ-1:0] exp_q[$];
  logic           exp_err_q[$];

  modex_controller #(.ARQ(ARQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base        (base),
    .exponent    (exponent),
    .modulus     (modulus),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .wr_reg_en   (wr_reg_en),
    .result      (result),
    .err         (err),
    .debug_state (debug_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, expv, expv, $time);
    end
  endtask

  // Reference: base^exp mod m by ordinary 64-bit arithmetic.
  function automatic logic [ARQ-1:0] ref_modexp(input logic [ARQ-1:0] bv, input logic [ARQ-1:0] ev,
                                                input logic [ARQ-1:0] mv);
    longint r, bb, mm;
    mm = longint'(mv);
    if (mm == 0) return '0;
    r  = 1 % mm;
    bb = longint'(bv) % mm;
    for (int i = 0; i < ARQ; i++) begin
      if (ev[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return ARQ'(r);
  endfunction

  // Reference: cycles from the start sampling edge to done.
  function automatic int ref_latency(input logic [ARQ-1:0] ev, input logic [ARQ-1:0] mv);
    int pc, bl, n;
    if (mv == '0) return 1;
    pc = 0;
    bl = 0;
    for (int i = 0; i < ARQ; i++) begin
      if (ev[i]) begin
        pc++;
        bl = i + 1;
      end
    end
    n = (ev == '0) ? 1 : (1 + pc + (bl - 1));
    return n * (ARQ + 1) + 1;
  endfunction

  // Issue one MODEX at the current negedge; optionally pulse a stray start
  // at cycle 'inject' (0 = none). Returns one negedge after done.
  task automatic run_op(input logic [ARQ-1:0] bv, input logic [ARQ-1:0] ev,
                        input logic [ARQ-1:0] mv, input int inject);
    int             cyc;
    bit             stall_ok;
    int             exp_lat;
    logic [ARQ-1:0] exp_res;
    logic           exp_err;
    exp_q.push_back(ref_modexp(bv, ev, mv));
    exp_err_q.push_back(mv == '0);
    exp_lat  = ref_latency(ev, mv);
    base     = bv;
    exponent = ev;
    modulus  = mv;
    start    = 1'b1;
    #1;
    check_eq("busy_idle", busy, 0);
    check_eq("stall_issue", stall, 1);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    stall_ok = 1'b1;
    while (!done && cyc < MAX_CYC) begin
      if (!stall || !busy || wr_reg_en) stall_ok = 1'b0;
      if (cyc == inject) begin
        start    = 1'b1;
        base     = ~bv;
        exponent = ev ^ 16'h00ff;
        modulus  = mv + 16'd3;
      end else begin
        start    = 1'b0;
        base     = bv;
        exponent = ev;
        modulus  = mv;
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    exp_res = exp_q.pop_front();
    exp_err = exp_err_q.pop_front();
    check_eq("done_seen", done, 1);
    check_eq("latency", cyc, exp_lat);
    check_eq("stall_busy_through_done", stall_ok & stall & busy, 1);
    check_eq("result", result, exp_res);
    check_eq("err", err, exp_err);
    check_eq("wr_reg_en", wr_reg_en, !exp_err);
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("busy_drop", busy, 0);
    check_eq("stall_drop", stall, 0);
    check_eq("result_hold", result, exp_res);
    check_eq("err_hold", err, exp_err);
  endtask

  // Start an operation and pull reset low at cycle at_cyc of the run.
  task automatic reset_mid_run(input logic [ARQ-1:0] bv, input logic [ARQ-1:0] ev,
                               input logic [ARQ-1:0] mv, input int at_cyc);
    int cyc;
    bit wrote;
    base     = bv;
    exponent = ev;
    modulus  = mv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    wrote = 1'b0;
    while (cyc < at_cyc) begin
      if (wr_reg_en || done) wrote = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_eq("busy_before_reset", busy, 1);
    rst = 1'b0;
    #1;
    check_eq("reset_outputs", {busy, stall, done, wr_reg_en, err, result}, 0);
    check_eq("no_partial_write", wrote, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [ARQ-1:0] rb, re, rm;
    int             inj;

    // reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {busy, stall, done, wr_reg_en, err, result}, 0);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    run_op(16'd20, 16'd28, 16'd45, 0);
    run_op(16'd50, 16'd1, 16'd45, 0);
    run_op(16'd2, 16'd16, 16'd65535, 0);
    run_op(16'd7, 16'd0, 16'd45, 0);
    run_op(16'd123, 16'd77, 16'd1, 0);
    run_op(16'd9, 16'd5, 16'd0, 0);

    // reset while idle clears the held err and result
    rst = 1'b0;
    #1;
    check_eq("reset_idle_clears", {err, result}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // stray start pulses mid-run are ignored
    run_op(16'd20, 16'd28, 16'd45, 40);
    run_op(16'd1234, 16'hbeef, 16'd40001, 100);

    // reset at cycle 50 of a long run, then a fresh run
    reset_mid_run(16'd333, 16'hffff, 16'd60000, 50);
    run_op(16'd20, 16'd28, 16'd45, 0);

    // random operations
    for (int k = 0; k < 25; k++) begin
      rb = ARQ'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       re = ARQ'($urandom_range(0, 15));
        default: re = ARQ'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 9))
        0:       rm = '0;
        1:       rm = 16'd1;
        2:       rm = 16'd65535;
        3:       rm = ARQ'($urandom_range(2, 100));
        default: rm = ARQ'($urandom_range(2, 65535));
      endcase
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      run_op(rb, re, rm, inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modex_controller.md
# modex_controller

Multi-cycle sequencer for the MODEX instruction of the 16-bit RSA ASIP. It computes `base^exponent mod modulus` by right-to-left square-and-multiply on a shared serial modular multiplier. While it works, it holds the fetch/decode pipeline by stalling the PC. It sits beside the EXE stage: operands come from the ID/EXE latch, and the result goes to the write-back path.

## Interface
- `ARQ`, default 16: datapath width in bits.
- `clk` (in, 1): clock, rising edge.
- `rst` (in, 1): reset, asynchronous, active-low.
- `start` (in, 1): MODEX issued; sampled only in IDLE.
- `base` (in, ARQ): base operand; any value, including values ≥ modulus.
- `exponent` (in, ARQ): exponent operand.
- `modulus` (in, ARQ): modulus operand.
- `stall` (out, 1): freeze request to IF/ID; drives `pc_enable` low.
- `busy` (out, 1): an operation is in progress.
- `done` (out, 1): one-cycle pulse; `result`/`err` valid in the same cycle.
- `wr_reg_en` (out, 1): register-file write strobe; equals `done & ~err`.
- `result` (out, ARQ): modular result; holds its value until the next `done`.
- `err` (out, 1): modulus was 0; valid with `done`, held until the next accepted `start`.

## Operation
- States: IDLE, REDUCE, MUL, SQR, NEXT, DONE.
- IDLE:
  - `start=1` latches `base`, `exponent` and `modulus`.
  - If `modulus==0`, go to DONE with `err=1` and `result=0`.
  - Otherwise set `acc = (modulus==1) ? 0 : 1` and go to REDUCE.
- REDUCE: `b = modmul(base, 1)`, which gives `base mod modulus`. Then go to NEXT.
- NEXT:
  - If `e==0`, go to DONE.
  - Else if `e[0]==1`, go to MUL; otherwise go to SQR.
- MUL: `acc = modmul(acc, b)`.
  - If `e>>1 == 0`, shift `e` and go to DONE.
  - Otherwise go to SQR.
- SQR: `b = modmul(b, b)`, then `e = e>>1`, then go to NEXT.
- DONE: pulse `done`, drive `result = acc`, return to IDLE.
- `start` during any state other than IDLE is ignored and has no effect on the operation in progress.
- `stall = busy | (start & state==IDLE)`. This is combinational, so the PC freezes in the same cycle MODEX is presented.
- Reset (`rst=0`) at any time, including mid-operation, forces the following. No partial result is ever written.
  - State = IDLE.
  - `busy`, `stall`, `done`, `wr_reg_en`, `err` = 0.
  - `result` = 0.
  - All internal registers = 0.
- Arithmetic rules:
  - All modmul operands are < `modulus`, except the REDUCE input `base`, which enters only through the multiplier-bit path.
  - The internal accumulator is ARQ+1 bits wide.
  - After every doubling and every addition, the accumulator is reduced by at most one conditional subtraction of `modulus`.

## Timing
- Each modmul takes exactly ARQ+1 cycles: 1 load cycle plus ARQ iterations, processed MSB-first.
- NEXT takes 0 cycles: its decision is folded into the transition out of the previous state.
- N = number of modmul operations:
  - N = 1 + popcount(exponent) + (bitlen(exponent) − 1) for exponent > 0.
  - N = 1 for exponent = 0.
- Latency from the `start` sampling edge to `done` high is N·(ARQ+1)+1 cycles.
- `busy` rises on the edge after `start` and falls in the cycle after `done`.
- `modulus==0`: `done` and `err` are high on the first edge after `start`, and `busy` is high for exactly 1 cycle.
- Back-to-back operation: a new `start` is accepted in the cycle after `done`.

## Structure
- Package `rsa_pkg` holds:
  - `ARQ`
  - `modex_state_t` enum (IDLE/REDUCE/MUL/SQR/DONE)
  - `modmul_op_t` (REDUCE/MUL/SQR), used for operand-mux selection
- Sub-module `modmul_serial`:
  - Ports: `clk`, `rst`, `go`, `a`, `b`, `m`, `valid`, `p`.
  - Implements an interleaved shift-add modular multiplier.
  - Contains a 5-bit iteration counter.
- `modex_controller` holds:
  - the FSM
  - the `acc`, `b` and `e` registers
  - the operand muxes feeding `modmul_serial`

## Test plan
- base=20, exp=28, mod=45:
  - `result=25` with `err=0`.
  - `done` at cycle 137 (N=8).
  - `stall` high from the `start` cycle through `done`.
- base=50, exp=1, mod=45 → `result=5`, latency 2·17+1 = 35 cycles.
- base=2, exp=16, mod=65535 → `result=1`.
- exp=0 (base=7, mod=45) → `result=1`, latency 18.
- Modulus boundary cases:
  - mod=1 → `result=0`.
  - mod=0 → `err=1` and `done` at cycle 1, with `wr_reg_en=0`.
- Reset and restart:
  - Pulse `start` again mid-run: it is ignored and the original result is unchanged.
  - Assert `rst=0` at cycle 50 of a run: all outputs are 0 immediately.
  - A fresh `start` after reset completes correctly.
